// File: rtl/simon_pkg.sv
// Shared types and helpers for the sequence-memory game engine.
// Holds the step limit, the colour type, the engine state enum and button-decoding helpers.
package simon_pkg;

  localparam int MAX_LEN = 32;

  typedef logic [1:0] colour_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TONE   = 2'd1,
    GAP    = 2'd2,
    LISTEN = 2'd3
  } engine_state_t;

  // Bits needed to count 0..count-1, never less than one.
  function automatic int width_for(input int count);
    return (count > 2) ? $clog2(count) : 1;
  endfunction

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic colour_t one_hot_index(input logic [3:0] v);
    colour_t idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = colour_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11; loads seed on reset.
// The seed must be nonzero or the register locks up at zero.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic feedback;

  assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else begin
      q <= {q[14:0], feedback};
    end
  end

endmodule

// File: rtl/seq_engine.sv
// Sequence-memory game engine: grows a random colour sequence, plays it back as timed
// tones, then checks the player's button presses against it.
module seq_engine
  import simon_pkg::*;
#(
  parameter int          MAX_LEN     = simon_pkg::MAX_LEN,
  parameter int          TONE_CYCLES = 25_000_000,
  parameter int          GAP_CYCLES  = 12_500_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       start_round,
  input  logic [3:0] btn,
  output logic [1:0] random_seq,
  output logic       tone_valid,
  output logic       end_of_sequence,
  output logic       correct_input,
  output logic       round_complete,
  output logic [5:0] seq_length
);

  localparam int TIMER_W = width_for((TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES);
  localparam logic [TIMER_W-1:0] TONE_LAST = TIMER_W'(TONE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [5:0]         LEN_FULL  = 6'(MAX_LEN);

  engine_state_t      state_reg, state_next;
  logic [5:0]         seq_len_reg, seq_len_next;
  logic [4:0]         play_idx_reg, play_idx_next;
  logic [4:0]         chk_idx_reg, chk_idx_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               correct_reg, correct_next;
  logic               eos_reg, eos_next;
  logic               rc_reg, rc_next;
  logic [3:0]         btn_prev_reg;
  colour_t            hold_colour_reg;

  logic [15:0] lfsr_q;
  logic [13:0] lfsr_unused;
  colour_t     mem [MAX_LEN];
  colour_t     play_colour;
  colour_t     chk_colour;
  logic        mem_we;
  logic        press;
  logic        press_ok;
  logic        last_play;
  logic        last_chk;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign lfsr_unused = lfsr_q[15:2];

  assign play_colour = mem[play_idx_reg];
  assign chk_colour  = mem[chk_idx_reg];
  assign last_play   = ({1'b0, play_idx_reg} == (seq_len_reg - 6'd1));
  assign last_chk    = ({1'b0, chk_idx_reg} == (seq_len_reg - 6'd1));

  // A press is the rising edge of "any button down"; held or re-keyed values are ignored.
  assign press    = (btn != 4'd0) && (btn_prev_reg == 4'd0);
  assign press_ok = is_one_hot(btn) && (one_hot_index(btn) == chk_colour);

  // Only the append path writes the sequence memory.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[seq_len_reg[4:0]] <= lfsr_q[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      seq_len_reg     <= '0;
      play_idx_reg    <= '0;
      chk_idx_reg     <= '0;
      timer_reg       <= '0;
      correct_reg     <= 1'b0;
      eos_reg         <= 1'b0;
      rc_reg          <= 1'b0;
      btn_prev_reg    <= '0;
      hold_colour_reg <= '0;
    end else begin
      state_reg    <= state_next;
      seq_len_reg  <= seq_len_next;
      play_idx_reg <= play_idx_next;
      chk_idx_reg  <= chk_idx_next;
      timer_reg    <= timer_next;
      correct_reg  <= correct_next;
      eos_reg      <= eos_next;
      rc_reg       <= rc_next;
      btn_prev_reg <= btn;
      if (state_reg == TONE) begin
        hold_colour_reg <= play_colour;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    seq_len_next  = seq_len_reg;
    play_idx_next = play_idx_reg;
    chk_idx_next  = chk_idx_reg;
    timer_next    = timer_reg;
    correct_next  = correct_reg;
    eos_next      = 1'b0;
    rc_next       = 1'b0;
    mem_we        = 1'b0;

    if (new_game) begin
      state_next    = IDLE;
      seq_len_next  = '0;
      play_idx_next = '0;
      chk_idx_next  = '0;
      timer_next    = '0;
      correct_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE, LISTEN: begin
          if (start_round) begin
            // A full sequence is replayed unchanged.
            if (seq_len_reg < LEN_FULL) begin
              mem_we       = 1'b1;
              seq_len_next = seq_len_reg + 6'd1;
            end
            play_idx_next = '0;
            chk_idx_next  = '0;
            timer_next    = '0;
            correct_next  = 1'b0;
            state_next    = TONE;
          end else if ((state_reg == LISTEN) && press) begin
            correct_next = press_ok;
            if (!press_ok) begin
              state_next = IDLE;
            end else if (last_chk) begin
              rc_next    = 1'b1;
              state_next = IDLE;
            end else begin
              chk_idx_next = chk_idx_reg + 5'd1;
            end
          end
        end
        TONE: begin
          if (timer_reg == TONE_LAST) begin
            timer_next = '0;
            state_next = GAP;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        GAP: begin
          if (timer_reg == GAP_LAST) begin
            timer_next = '0;
            if (last_play) begin
              eos_next     = 1'b1;
              chk_idx_next = '0;
              state_next   = LISTEN;
            end else begin
              play_idx_next = play_idx_reg + 5'd1;
              state_next    = TONE;
            end
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The colour tracks memory while sounding and keeps the last step afterwards.
  assign random_seq      = (state_reg == TONE) ? play_colour : hold_colour_reg;
  assign tone_valid      = (state_reg == TONE);
  assign end_of_sequence = eos_reg;
  assign correct_input   = correct_reg;
  assign round_complete  = rc_reg;
  assign seq_length      = seq_len_reg;

endmodule

// File: tb/tb_seq_engine.sv
// Randomised scoreboard bench for seq_engine with short tone/gap timing.
// The driver keeps a game-level model and queues expectations; a negedge monitor compares.
module tb_seq_engine;

  localparam int          TONE = 4;
  localparam int          GAP  = 2;
  localparam int          MAXL = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int K_SEQLEN = 0;
  localparam int K_TONE   = 1;
  localparam int K_RSEQ   = 2;
  localparam int K_EOS    = 3;
  localparam int K_CI     = 4;
  localparam int K_RC     = 5;
  localparam int K_EOSCNT = 6;
  localparam int K_TONEQ  = 7;

  typedef struct {
    int due;
    int kind;
    int exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic       start_round = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [1:0] random_seq;
  logic       tone_valid;
  logic       end_of_sequence;
  logic       correct_input;
  logic       round_complete;
  logic [5:0] seq_length;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] model_lfsr;

  exp_t exp_q[$];
  int   tone_q[$];
  int   exp_rd = 0;
  int   tone_rd = 0;
  int   eos_seen = 0;
  int   exp_eos = 0;
  int   abort_cnt = 0;
  int   abort_seen = 0;

  int model_seq[$];
  int model_len = 0;
  int model_chk = 0;
  bit model_ci = 1'b0;
  bit listening = 1'b0;

  seq_engine #(
    .MAX_LEN     (MAXL),
    .TONE_CYCLES (TONE),
    .GAP_CYCLES  (GAP),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .new_game        (new_game),
    .start_round     (start_round),
    .btn             (btn),
    .random_seq      (random_seq),
    .tone_valid      (tone_valid),
    .end_of_sequence (end_of_sequence),
    .correct_input   (correct_input),
    .round_complete  (round_complete),
    .seq_length      (seq_length)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: reset to the seed, otherwise shift in taps 16,14,13,11 every cycle.
  always @(posedge clk) begin
    if (rst) model_lfsr <= SEED;
    else model_lfsr <= {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1);
  end

  // ---------------- monitor / scoreboard ----------------
  bit   prev_tone = 1'b0;
  bit   in_gap = 1'b0;
  bit   rc_checked;
  int   tone_cnt = 0;
  int   gap_cnt = 0;
  int   cur_col = 0;
  exp_t e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (end_of_sequence) eos_seen++;
    if (abort_seen != abort_cnt) begin
      abort_seen = abort_cnt;
      tone_rd    = tone_q.size();
      in_gap     = 1'b0;
      prev_tone  = 1'b0;
      tone_cnt   = 0;
    end else begin
      if (tone_valid && !prev_tone) begin
        if (in_gap) check("gap_len", gap_cnt, GAP);
        in_gap = 1'b0;
        check("step_pending", int'(tone_q.size() > tone_rd), 1);
        if (tone_q.size() > tone_rd) begin
          cur_col = tone_q[tone_rd];
          tone_rd++;
          check("step_colour", int'(random_seq), cur_col);
        end
        tone_cnt = 1;
      end else if (tone_valid) begin
        tone_cnt++;
      end else if (prev_tone) begin
        check("tone_len", tone_cnt, TONE);
        check("gap_colour_hold", int'(random_seq), cur_col);
        in_gap  = 1'b1;
        gap_cnt = 1;
      end else if (in_gap && !end_of_sequence) begin
        gap_cnt++;
      end
      if (end_of_sequence) begin
        check("eos_after_gap", int'(in_gap), 1);
        if (in_gap) check("last_gap_len", gap_cnt, GAP);
        check("eos_steps_left", tone_q.size() - tone_rd, 0);
        in_gap = 1'b0;
      end
      prev_tone = tone_valid;
    end

    rc_checked = 1'b0;
    while (exp_rd < exp_q.size() && exp_q[exp_rd].due <= cyc) begin
      e = exp_q[exp_rd];
      exp_rd++;
      case (e.kind)
        K_SEQLEN: check("seq_length", int'(seq_length), e.exp);
        K_TONE:   check("tone_valid", int'(tone_valid), e.exp);
        K_RSEQ:   check("random_seq", int'(random_seq), e.exp);
        K_EOS:    check("end_of_sequence", int'(end_of_sequence), e.exp);
        K_CI:     check("correct_input", int'(correct_input), e.exp);
        K_RC: begin
          check("round_complete", int'(round_complete), e.exp);
          rc_checked = 1'b1;
        end
        K_EOSCNT: check("eos_count", eos_seen, e.exp);
        K_TONEQ:  check("steps_unplayed", tone_q.size() - tone_rd, e.exp);
        default:  check("exp_kind", e.kind, 0);
      endcase
    end
    if (!rc_checked && round_complete) check("rc_spurious", int'(round_complete), 0);
  end

  // ---------------- driver and game model ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int ex, input int off);
    exp_t n;
    n.due  = cyc + off;
    n.kind = kind;
    n.exp  = ex;
    exp_q.push_back(n);
  endtask

  function automatic logic [3:0] oh(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return v;
  endfunction

  task automatic model_clear();
    model_seq.delete();
    model_len = 0;
    model_chk = 0;
    model_ci  = 1'b0;
    listening = 1'b0;
  endtask

  task automatic push_reset_state();
    push(K_SEQLEN, 0, 0);
    push(K_TONE, 0, 0);
    push(K_RSEQ, 0, 0);
    push(K_EOS, 0, 0);
    push(K_CI, 0, 0);
    push(K_RC, 0, 0);
  endtask

  task automatic press(input logic [3:0] v, input int hold);
    int ones;
    int idx;
    bit ok;
    bit rc;
    rc = 1'b0;
    if (listening) begin
      ones = 0;
      idx  = -1;
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          ones++;
          idx = i;
        end
      end
      ok = (ones == 1) && (idx == model_seq[model_chk]);
      model_ci = ok;
      if (ok && model_chk == model_len - 1) begin
        rc = 1'b1;
        listening = 1'b0;
      end else if (ok) begin
        model_chk++;
      end else begin
        listening = 1'b0;
      end
    end
    $display("press btn=%b hold=%0d expect correct=%0d complete=%0d", v, hold, model_ci, rc);
    btn = v;
    push(K_CI, int'(model_ci), 1);
    push(K_RC, int'(rc), 1);
    repeat (hold) tick();
    btn = 4'd0;
    repeat (2) tick();
  endtask

  task automatic issue_round(input bit noise);
    start_round = 1'b1;
    if (model_len < MAXL) begin
      model_seq.push_back(int'(model_lfsr[1:0]));
      model_len++;
    end
    model_ci  = 1'b0;
    listening = 1'b0;
    model_chk = 0;
    foreach (model_seq[i]) tone_q.push_back(model_seq[i]);
    exp_eos++;
    $display("round len=%0d newest colour=%0d", model_len, model_seq[model_len-1]);
    tick();
    start_round = 1'b0;
    push(K_SEQLEN, model_len, 0);
    if (noise) press(oh($urandom_range(3, 0)), 1);
  endtask

  task automatic wait_eos();
    int budget;
    budget = model_len * (TONE + GAP) + 10;
    for (int n = 0; n < budget && eos_seen < exp_eos; n++) tick();
    if (eos_seen < exp_eos) push(K_EOSCNT, exp_eos, 0);
    listening = 1'b1;
    model_chk = 0;
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    model_clear();
    tick();
    new_game = 1'b0;
    push(K_SEQLEN, 0, 0);
    push(K_CI, 0, 0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    repeat (3) tick();
    push_reset_state();
    rst = 1'b0;
    tick();
    do_new_game();

    // First round: exact tone/gap/end timing.
    issue_round(1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      push(K_TONE, int'(k <= 3), 0);
      push(K_EOS, int'(k == 6), 0);
    end
    wait_eos();
    press(oh(model_seq[0]), 1);
    press(4'b0001, 1);

    // Second round: noise during playback, first press held for 10 cycles.
    issue_round(1'b1);
    wait_eos();
    press(oh(model_seq[0]), 10);
    press(oh(model_seq[1]), 2);

    issue_round(1'b0);
    wait_eos();
    for (int i = 0; i < 3; i++) press(oh(model_seq[i]), 1 + i);

    // Multi-hot press ends the round; later presses are ignored.
    issue_round(1'b0);
    wait_eos();
    press(oh(model_seq[0]), 1);
    press(4'b0011, 1);
    push(K_SEQLEN, 4, 0);
    press(oh(model_seq[1]), 1);

    for (int r = 0; r < 4; r++) begin
      issue_round(bit'($urandom_range(1, 0)));
      wait_eos();
      while (listening) begin
        c = model_seq[model_chk];
        if ($urandom_range(5, 0) == 0) c = (c + 1 + int'($urandom_range(2, 0))) % 4;
        press(oh(c), int'($urandom_range(3, 1)));
      end
    end

    // Saturation: the 33rd round replays 32 steps.
    do_new_game();
    for (int k = 1; k <= 33; k++) begin
      issue_round(1'b0);
      wait_eos();
    end

    // new_game beats start_round during TONE.
    do_new_game();
    issue_round(1'b0);
    tick();
    new_game = 1'b1;
    start_round = 1'b1;
    abort_cnt++;
    model_clear();
    exp_eos--;
    tick();
    new_game = 1'b0;
    start_round = 1'b0;
    push(K_SEQLEN, 0, 0);
    push(K_TONE, 0, 0);
    repeat (10) tick();

    // Reset during GAP.
    issue_round(1'b0);
    repeat (4) tick();
    push(K_TONE, 0, 0);
    rst = 1'b1;
    abort_cnt++;
    model_clear();
    exp_eos--;
    tick();
    rst = 1'b0;
    push_reset_state();
    repeat (12) tick();

    issue_round(1'b0);
    wait_eos();
    press(oh(model_seq[0]), 1);

    push(K_EOSCNT, exp_eos, 0);
    push(K_TONEQ, 0, 0);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_engine.md
SEQ_ENGINE -- requirements
Module: seq_engine

Interface
REQ-001 Parameter MAX_LEN, 32, maximum sequence length (steps).
REQ-002 Parameter TONE_CYCLES, 25_000_000, clk cycles each step is presented.
REQ-003 Parameter GAP_CYCLES, 12_500_000, silent clk cycles between steps.
REQ-004 Parameter LFSR_SEED, 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-005 Port clk, input, 1, single clock; all logic on posedge clk.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port new_game, input, 1, pulse: clear stored sequence.
REQ-008 Port start_round, input, 1, pulse: append one step, start playback.
REQ-009 Port btn, input, 4, raw player buttons, already debounced.
REQ-010 Port random_seq, output, 2, colour index of the step being played.
REQ-011 Port tone_valid, output, 1, high while a step is presented.
REQ-012 Port end_of_sequence, output, 1, one-cycle pulse after the last step's gap.
REQ-013 Port correct_input, output, 1, registered result of the latest press.
REQ-014 Port round_complete, output, 1, one-cycle pulse when the full sequence is entered correctly.
REQ-015 Port seq_length, output, 6, number of stored steps (0..MAX_LEN).

Function
REQ-016 States: IDLE, TONE, GAP, LISTEN; reset state IDLE.
REQ-017 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle; new_game SHALL NOT reseed it.
REQ-018 new_game SHALL force seq_length=0, state=IDLE, and clear all index counters next cycle; it wins over a simultaneous start_round.
REQ-019 start_round in IDLE or LISTEN: if seq_length<MAX_LEN, write lfsr[1:0] to mem[seq_length] and increment seq_length; if seq_length==MAX_LEN, no write (replay only). Then play_idx=0, state=TONE.
REQ-020 start_round in TONE or GAP SHALL be ignored.
REQ-021 TONE: random_seq=mem[play_idx], tone_valid=1 for exactly TONE_CYCLES cycles, then GAP.
REQ-022 GAP: tone_valid=0, random_seq holds, for exactly GAP_CYCLES cycles; then if play_idx==seq_length-1, pulse end_of_sequence, chk_idx=0, state=LISTEN; else play_idx+1, state=TONE.
REQ-023 LISTEN: a press is btn!=0 this cycle with btn==0 the previous cycle; held or repeated non-zero values SHALL NOT register.
REQ-024 Press evaluation: correct iff btn is one-hot and its index equals mem[chk_idx]; multi-hot SHALL be incorrect.
REQ-025 correct_input SHALL update one cycle after the press and hold until the next press, new_game, or start_round (cleared to 0).
REQ-026 Correct press with chk_idx==seq_length-1: pulse round_complete with the correct_input update, state=IDLE; otherwise chk_idx+1.
REQ-027 Incorrect press: correct_input=0, state=IDLE, seq_length retained.
REQ-028 Presses outside LISTEN SHALL be ignored.
REQ-029 Timer counter width is sized from max(TONE_CYCLES,GAP_CYCLES); indices are 5 bits, no wrap beyond MAX_LEN-1.

Reset
REQ-030 rst SHALL give: state IDLE, seq_length 0, random_seq 0, tone_valid 0, end_of_sequence 0, correct_input 0, round_complete 0, lfsr LFSR_SEED, btn history 0; mem contents are don't-care.
REQ-031 rst mid-playback or mid-listen SHALL abort within one cycle, with no stale pulse after release.

Structure
REQ-032 The shared package simon_pkg SHALL hold MAX_LEN, the colour_t 2-bit type, and the engine state enum.
REQ-033 The LFSR SHALL be a sub-module lfsr16 (clk, rst, seed, q[15:0]).
REQ-034 Sequence memory SHALL be a MAX_LEN x 2 register array, written in one place only.

Verification (TONE_CYCLES=4, GAP_CYCLES=2)
REQ-035 rst, then new_game, then start_round -> seq_length=1; tone_valid high 4 cycles, low 2; end_of_sequence pulses once on cycle 7.
REQ-036 Three rounds: press correct colours with a release between each -> correct_input=1 after each press, round_complete once after the third, state IDLE.
REQ-037 In LISTEN, press btn=4'b0011 -> correct_input=0, state IDLE, seq_length unchanged.
REQ-038 Hold a correct button for 10 cycles -> exactly one chk_idx advance.
REQ-039 Issue 33 start_rounds -> seq_length saturates at 32; 33rd playback plays 32 steps.
REQ-040 new_game and start_round in the same cycle during TONE; rst during GAP -> seq_length=0, IDLE, no end_of_sequence pulse.
